// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator family: FSM encoding and default sizes.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int R_DEF     = 8;
  localparam int PRESC_DEF = 50000;

endpackage

// File: rtl/pwm_rampa_ctrl_if.sv
// Request/status bundle between the control logic and the duty-cycle ramp sequencer.
interface pwm_rampa_ctrl_if
  import pwm_pkg::*;
#(
  parameter int R      = R_DEF,
  parameter int RATE_W = 8
);
  logic              req;
  logic [R-1:0]      target;
  logic [RATE_W-1:0] rate;
  logic              abort;
  logic              ack;
  logic              busy;
  logic              done;
  logic [R-1:0]      ciclo;

  modport master (
    output req, target, rate, abort,
    input  ack, busy, done, ciclo
  );

  modport slave (
    input  req, target, rate, abort,
    output ack, busy, done, ciclo
  );
endinterface

// File: rtl/pwm_tick_gen.sv
// Base-tick prescaler: one-cycle tick every PRESC clocks, restartable on clr.
module pwm_tick_gen #(
  parameter int PRESC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = (PRESC > 2) ? $clog2(PRESC) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt == CW'(PRESC - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(PRESC - 1));

endmodule

// File: rtl/pwm_rampa_ctrl.sv
// Duty-cycle ramp sequencer: walks ciclo toward a requested target one LSB per
// programmable number of base ticks, with abort and a completion pulse.
module pwm_rampa_ctrl
  import pwm_pkg::*;
#(
  parameter int R      = R_DEF,
  parameter int PRESC  = PRESC_DEF,
  parameter int RATE_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  pwm_rampa_ctrl_if.slave bus
);
  state_t            state, state_nxt;
  logic [R-1:0]      ciclo, tgt, ciclo_nxt;
  logic [RATE_W-1:0] rate_l, step_cnt;
  logic              tick, accept, ramping, step_hit, do_step;
  logic              moving, ack, done, ack_d, done_d, busy;

  // Saturating one-LSB move; the direction is fixed at accept so the clamp never bites
  function automatic logic [R-1:0] sat_step(input logic [R-1:0] v, input logic up);
    if (up) begin
      return (v == '1) ? v : v + R'(1);
    end
    return (v == '0) ? v : v - R'(1);
  endfunction

  pwm_tick_gen #(.PRESC(PRESC)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .tick  (tick)
  );

  assign accept    = (state == IDLE) && bus.req && !bus.abort;
  assign ramping   = (state == UP) || (state == DOWN);
  assign step_hit  = (step_cnt + RATE_W'(1)) == rate_l;
  assign do_step   = ramping && !bus.abort && tick && step_hit;
  assign ciclo_nxt = sat_step(ciclo, state == UP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.target > ciclo) begin
            state_nxt = UP;
          end else if (bus.target < ciclo) begin
            state_nxt = DOWN;
          end else begin
            state_nxt = FIN;
          end
        end
      end
      UP, DOWN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (do_step && (ciclo_nxt == tgt)) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy also covers the FIN cycle of a real ramp so it drops together with done
  always_comb begin
    ack_d  = accept;
    done_d = (state == FIN);
    busy   = ramping || ((state == FIN) && moving);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack      <= 1'b0;
      done     <= 1'b0;
      moving   <= 1'b0;
      step_cnt <= '0;
      ciclo    <= '0;
    end else begin
      ack  <= ack_d;
      done <= done_d;
      if (accept) begin
        moving   <= (bus.target != ciclo);
        step_cnt <= '0;
      end else if (ramping && tick) begin
        step_cnt <= step_hit ? '0 : step_cnt + RATE_W'(1);
      end
      if (do_step) begin
        ciclo <= ciclo_nxt;
      end
    end
  end

  // Latched request operands; a rate of zero behaves as one
  always_ff @(posedge clk) begin
    if (accept) begin
      tgt    <= bus.target;
      rate_l <= (bus.rate == '0) ? RATE_W'(1) : bus.rate;
    end
  end

  assign bus.ack   = ack;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.ciclo = ciclo;

endmodule

// File: tb/tb_pwm_rampa_ctrl.sv
// Scoreboard bench for pwm_rampa_ctrl with PRESC=4, R=8: expected ack/ciclo/done events are queued at issue time.
module tb_pwm_rampa_ctrl;

  localparam int EV_ACK  = 0;
  localparam int EV_CIC  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int    kind;
    int    val;
    int    cyc;
    bit    busy;
    string name;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [7:0] prev_ciclo = '0;
  ev_t  sb[$];

  pwm_rampa_ctrl_if #(.R(8), .RATE_W(8)) bus ();

  pwm_rampa_ctrl #(.R(8), .PRESC(4), .RATE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cyc %0d, want none", kind, val, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc || e.busy != bus.busy) begin
        errors++;
        $display("FAIL %s: got kind=%0d val=%0d cyc=%0d busy=%0d, want kind=%0d val=%0d cyc=%0d busy=%0d",
                 e.name, kind, val, cyc, bus.busy, e.kind, e.val, e.cyc, e.busy);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.ack) check_ev(EV_ACK, 0);
        if (bus.ciclo != prev_ciclo) check_ev(EV_CIC, int'(bus.ciclo));
        if (bus.done) check_ev(EV_DONE, 0);
      end
      prev_ciclo = bus.ciclo;
    end
  end

  task automatic push(input int kind, input int val, input int at, input bit b, input string nm);
    ev_t e;
    e.kind = kind; e.val = val; e.cyc = at; e.busy = b; e.name = nm;
    sb.push_back(e);
  endtask

  // Call right after a negedge; returns one cycle later, in the ack cycle
  task automatic issue(input int tgt, input int rt, input int from, input int n_push, input bit with_done);
    int c, step, n;
    step = 4 * ((rt == 0) ? 1 : rt);
    n = (tgt > from) ? tgt - from : from - tgt;
    c = cyc;
    bus.req = 1'b1;
    bus.target = 8'(tgt);
    bus.rate = 8'(rt);
    push(EV_ACK, 0, c + 1, tgt != from, "ack");
    for (int k = 1; k <= n && k <= n_push; k++)
      push(EV_CIC, (tgt > from) ? from + k : from - k, c + 1 + k * step, 1'b1, "ciclo_step");
    if (with_done) push(EV_DONE, 0, c + 1 + n * step + 1, 1'b0, "done");
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_sb(input int budget, input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending events, want 0", tag, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ciclo(input int v, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(bus.ciclo) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(bus.ciclo), v);
  endtask

  initial begin
    int busy_cnt;
    reset = 1'b1;
    bus.req = 1'b0;
    bus.target = '0;
    bus.rate = '0;
    bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ciclo", int'(bus.ciclo), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Up ramp 0 -> 3, rate 2
    issue(3, 2, 0, 255, 1'b1);
    wait_sb(60, "up_0_3");

    // Equal target: ack then done, busy never high
    issue(3, 5, 3, 255, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    chk("eq_busy_cycles", busy_cnt, 0);
    wait_sb(10, "equal");

    // Down ramp 3 -> 0, rate 0 behaves as 1
    issue(0, 0, 3, 255, 1'b1);
    wait_sb(40, "down_3_0");

    // Abort at ciclo 4 of a 0 -> 10 ramp
    issue(10, 1, 0, 4, 1'b0);
    wait_ciclo(4, 40, "abort_reach4");
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_hold_ciclo", int'(bus.ciclo), 4);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_sb_empty", sb.size(), 0);

    // Request while busy is ignored; the ongoing 4 -> 8 ramp proceeds unchanged
    issue(8, 1, 4, 255, 1'b1);
    @(negedge clk);
    bus.req = 1'b1;
    bus.target = 8'd0;
    bus.rate = 8'd3;
    repeat (3) @(negedge clk);
    bus.req = 1'b0;
    wait_sb(40, "ignored_req");
    chk("ignored_final", int'(bus.ciclo), 8);

    // Reset mid-ramp at ciclo 5
    issue(0, 1, 8, 3, 1'b0);
    wait_ciclo(5, 40, "midramp_reach5");
    @(negedge clk);
    chk("midramp_sb_empty", sb.size(), 0);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ciclo", int'(bus.ciclo), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_ack", int'(bus.ack), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_ciclo", int'(bus.ciclo), 0);
    chk("post_rst_busy", int'(bus.busy), 0);
    mon_en = 1'b1;

    // Fresh ramp proves the FSM sits in IDLE after reset
    issue(2, 1, 0, 255, 1'b1);
    wait_sb(30, "post_rst_ramp");
    issue(0, 1, 2, 255, 1'b1);
    wait_sb(30, "back_to_0");

    // Full-scale ramps: no wrap at either end
    issue(255, 1, 0, 255, 1'b1);
    wait_sb(1100, "full_up");
    repeat (8) @(negedge clk);
    chk("full_up_hold", int'(bus.ciclo), 255);
    issue(0, 1, 255, 255, 1'b1);
    wait_sb(1100, "full_down");
    repeat (8) @(negedge clk);
    chk("full_down_hold", int'(bus.ciclo), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pwm_rampa_ctrl.md
# pwm_rampa_ctrl

Duty-cycle sequencer that drives the `ciclo` input of the basic PWM generator. On a request it ramps the duty cycle from its current value to a requested target, one LSB per programmable step interval, then signals completion. It sits between the game/control logic and the PWM block, so LED/buzzer brightness and volume changes are smooth rather than abrupt.

## Interface
- `R`, 8: duty-cycle width; must match the PWM generator.
- `PRESC`, 50000: clock cycles per base tick, ≥2; 1 ms at 50 MHz.
- `RATE_W`, 8: width of the `rate` input.

- `clk`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req`, in, 1: ramp request, level-sampled.
- `target`, in, R: requested final duty; sampled on accept.
- `rate`, in, RATE_W: base ticks per 1-LSB step; sampled on accept; 0 treated as 1.
- `abort`, in, 1: stop ramp, hold current duty.
- `ack`, out, 1: one-cycle pulse, request accepted.
- `busy`, out, 1: high while ramping.
- `done`, out, 1: one-cycle pulse, target reached.
- `ciclo`, out, R: duty cycle to the PWM generator.

## Operation
- States: IDLE, UP, DOWN, FIN.
- **IDLE**
  - If `req`=1 and `abort`=0: latch `target` and `rate`, pulse `ack`, and restart the prescaler and step counter.
  - Next state is UP if target > ciclo, DOWN if target < ciclo, FIN if equal.
- **UP/DOWN**
  - Each base tick increments the step counter.
  - When the step counter reaches the latched rate, `ciclo` moves ±1 and the step counter clears.
  - When the updated `ciclo` equals the target, next state is FIN.
- **FIN**: pulse `done` for one cycle, then return to IDLE.
- `abort` in UP/DOWN: go to IDLE next cycle; `ciclo` holds its value; no `done`. `abort` has priority over a step in the same cycle.
- `req` while not IDLE: ignored, no `ack`, not queued.
- `req` held high in IDLE after FIN: a new ramp is accepted. A `req` held continuously restarts a ramp every time IDLE is reached.
- Arithmetic: `ciclo` is unsigned R-bit and never wraps. The direction is fixed at accept, so overshoot is impossible. Ramps can go 0→2^R−1 and back.
- `busy` = state is UP or DOWN.

## Timing
- Reset values: `ciclo`=0, `ack`=0, `busy`=0, `done`=0, state IDLE, prescaler=0, step counter=0.
- Reset takes effect at the first `clk` edge where `reset`=1, including mid-ramp. It overrides `req` and `abort`.
- `ack` is asserted in the cycle after `req` is sampled. `busy` rises in that same cycle when target ≠ ciclo.
- Base tick: prescaler counts 0..PRESC−1 and produces a tick when it reaches PRESC−1.
- The first `ciclo` change occurs PRESC·rate cycles after the `ack` cycle. Later changes are spaced PRESC·rate cycles apart.
- A full ramp of N LSB takes N·PRESC·rate cycles from `ack` to the final `ciclo` update.
- `done` follows the final update by 1 cycle; `busy` falls in that same cycle.
- target = ciclo at accept: `busy` stays low and `done` pulses 1 cycle after `ack`.
- `ciclo` is registered, so there is no combinational path from any input.

## Structure
- Shared package `pwm_pkg`:
  - state encoding constants (IDLE=2'd0, UP=2'd1, DOWN=2'd2, FIN=2'd3);
  - default `R` and `PRESC` constants, shared with the PWM generator.
- Sub-module `pwm_tick_gen`:
  - ports: `clk`, `reset`, `clr`, `tick`;
  - parameter `PRESC`;
  - generates the one-cycle base tick and restarts on `clr`, driven by accept.
- The top module holds the FSM, step counter, latched target/rate and the `ciclo` register.

## Test plan
Bench settings: PRESC=4, R=8.
1. Reset mid-ramp (ciclo=5), then `reset`=1 for 1 cycle → all outputs 0 and state IDLE on the next edge.
2. Up ramp from ciclo=0: `req` with target=3, rate=2 → `ack` at the following cycle, ciclo=1/2/3 at +8/+16/+24 cycles after `ack`, `done` at +25, `busy` high from `ack` to +24.
3. Down ramp from ciclo=3: target=0, rate=0 → steps every 4 cycles, `done` 13 cycles after `ack`.
4. Equal target: ciclo=3, `req` with target=3 → `ack`, then `done` 1 cycle later, `busy` never high.
5. Abort and ignored request: ramp 0→10, rate=1, assert `abort` when ciclo=4 → ciclo holds 4, no `done`. A `req` raised while `busy` gets no `ack` and changes nothing.
6. Wrap check: ramp 0→255, rate=1 → ciclo stops at 255 with no wrap, `done` once. Then a ramp 255→0 reaches exactly 0.
